mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single 128-bit memory port between the instruction cache and the data cache. It sits between both cache instances and the memory model. Each cache drives a level-held `mem_read`/`mem_write` request and drops it only after it samples its own `mem_ready`. The arbiter grants one cache at a time, registers that cache's request onto the memory port, routes the memory's ready pulse back to the granted cache, and waits for that cache to release its request before granting again.

## Interface
Parameters:
- ADDR_W, 28, block address width (word address >> 2)
- DATA_W, 128, block data width

Ports:
- clk  input  1  clock; all state on rising edge
- proc_reset_n  input  1  asynchronous active-low reset
- i_mem_read  input  1  I-cache read request, level-held
- i_mem_write  input  1  I-cache write request, level-held
- i_mem_addr  input  ADDR_W  I-cache block address
- i_mem_wdata  input  DATA_W  I-cache write data
- i_mem_rdata  output  DATA_W  read data to I-cache
- i_mem_ready  output  1  completion pulse to I-cache
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same widths and meaning, for the D-cache
- mem_read  output  1  registered read request to memory
- mem_write  output  1  registered write request to memory
- mem_addr  output  ADDR_W  registered address to memory
- mem_wdata  output  DATA_W  registered write data to memory
- mem_rdata  input  DATA_W  memory read data
- mem_ready  input  1  memory completion pulse, 1 cycle
- arb_busy  output  1  high in BUSY or RELEASE

## Operation
- A requester is active when its read or write input is high.
- If a requester asserts both read and write, write wins and the forwarded `mem_read` is 0.
- States: IDLE, BUSY, RELEASE. Grant register `gnt` (0 = I, 1 = D). Pointer `last` holds the last completed grantee.
- **IDLE:**
  - If no requester is active, stay in IDLE.
  - Otherwise select a winner (see Configuration) and latch its addr, wdata, read and write into the mem_* registers.
  - Set `gnt` to the winner and go to BUSY.
- **BUSY:**
  - Hold the mem_* registers constant. Ignore requester input changes.
  - On `mem_ready`, clear `mem_read`/`mem_write` at that edge and go to RELEASE.
- **RELEASE:**
  - Stay until the granted requester has both read and write low.
  - Then set `last <= gnt` and go to IDLE.
  - A `mem_ready` seen in RELEASE or IDLE is ignored and never forwarded.
- **Ready routing (combinational):**
  - `i_mem_ready` = mem_ready & BUSY & gnt==0.
  - `d_mem_ready` = mem_ready & BUSY & gnt==1.
- `mem_rdata` is broadcast unchanged to both `i_mem_rdata` and `d_mem_rdata`.
- A D-cache write-back followed by an allocate read is two separate transactions. The write drops for at least one cycle before the read rises, so the arbiter may grant the I-cache between them.

## Timing
- **Reset values:** state=IDLE, gnt=0, last=0 (I), mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, arb_busy=0.
- **Reset mid-transaction:** mem_read/mem_write drop immediately (asynchronously). The transaction is abandoned and no ready is forwarded.
- **Request to memory:**
  - A request active in IDLE at edge t appears on mem_* during cycle t+1.
  - arb_busy is high from t+1.
- **Ready forwarding:** zero latency, in the same cycle as `mem_ready`.
- mem_read/mem_write are low from the cycle after `mem_ready`.
- **Cache release timing:**
  - A cache with a registered ready drops its request one cycle after the ready.
  - So RELEASE normally lasts 1 cycle, and IDLE is re-entered 2 cycles after `mem_ready`.
- Minimum spacing between back-to-back grants: `mem_ready` cycle + 2 cycles.
- No combinational path exists from the requester inputs to mem_*.

## Configuration
- **With `MEM_ARB_RR_EN` defined:** round-robin arbitration.
  - When both caches are active in IDLE, grant the one not equal to `last`.
  - When only one is active, grant it.
  - After reset `last`=I, so the D-cache wins the first tie.
- **Without the macro:** fixed priority. The D-cache always wins a tie and `last` is unused. The I-cache can starve; this is acceptable for bring-up.

## Test plan
- **Single I read:** i_mem_read=1, i_mem_addr=28'h0000123, memory ready after 5 cycles with rdata=128'hA5…A5 → mem_read=1 and mem_addr=28'h0000123 one cycle later; i_mem_ready pulses once; d_mem_ready stays 0.
- **D write-back then allocate:** d_mem_write with addr 28'h00000F0 and wdata=128'h1, then d_mem_read with addr 28'h0000010 → two transactions; mem_write and mem_read are never high together; RELEASE is entered once per transaction.
- **Tie, RR build:** both caches request in the same cycle after reset → D granted first, then I; with the macro off, D is granted first and D again if it re-requests before I is served.
- **Simultaneous read+write on D:** d_mem_read=1 and d_mem_write=1 → mem_write=1, mem_read=0.
- **Stray ready:** mem_ready pulse in IDLE → both *_mem_ready stay 0 and the state stays IDLE.
- **Reset in BUSY:** proc_reset_n low 3 cycles after grant → mem_read=0 immediately; after release, the next request is re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one 128-bit memory port between the I-cache and D-cache.
// Build option: define MEM_ARB_RR_EN for round-robin ties; otherwise the D-cache wins every tie.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  // I-cache side
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // status / debug
  output logic              arb_busy,
  output logic [1:0]        arb_state
);

  // Handshake: a cache holds read/write (level) until it has sampled its own
  // ready; memory answers a registered request with a one-cycle mem_ready.
  // The arbiter forwards that ready only while BUSY, then waits in RELEASE
  // until the granted cache lets go before it will arbitrate again.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic gnt;        // 0 = I-cache, 1 = D-cache
  logic win;
  logic i_act;
  logic d_act;
  logic any_act;
  logic gnt_idle;

  assign i_act    = i_mem_read | i_mem_write;
  assign d_act    = d_mem_read | d_mem_write;
  assign any_act  = i_act | d_act;
  assign gnt_idle = gnt ? ~d_act : ~i_act;

`ifdef MEM_ARB_RR_EN
  logic last;       // last completed grantee

  assign win = (i_act & d_act) ? ~last : d_act;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      last <= 1'b0;
    end else if (state == RELEASE && gnt_idle) begin
      last <= gnt;
    end
  end
`else
  assign win = d_act;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_act)   state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RELEASE;
      RELEASE: if (gnt_idle)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request registers: loaded once at grant, frozen while BUSY; write wins over read.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      gnt       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && any_act) begin
      gnt <= win;
      if (win) begin
        mem_write <= d_mem_write;
        mem_read  <= d_mem_read & ~d_mem_write;
        mem_addr  <= d_mem_addr;
        mem_wdata <= d_mem_wdata;
      end else begin
        mem_write <= i_mem_write;
        mem_read  <= i_mem_read & ~i_mem_write;
        mem_addr  <= i_mem_addr;
        mem_wdata <= i_mem_wdata;
      end
    end else if (state == BUSY && mem_ready) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  assign i_mem_ready = mem_ready & (state == BUSY) & ~gnt;
  assign d_mem_ready = mem_ready & (state == BUSY) &  gnt;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign arb_busy    = (state != IDLE);
  assign arb_state   = state;

endmodule
